// File: rtl/hopfield_pkg.sv
// ---------------------------------------------------------------------------
// hopfield_pkg
//
// Shared definitions for the Hopfield network iteration logic.
//   - Controller state encodings (kept as plain localparam constants so that
//     older tools and hand-written netlists can match the encoding directly).
//   - Canonical bipolar state values used by the neurons: +1, -1 (all ones)
//     and 0.
//   - elem_t, the default-width state element type.
// ---------------------------------------------------------------------------
package hopfield_pkg;

  // Default element width used by the standard neuron.
  localparam int ELEM_WIDTH = 32;

  typedef logic [ELEM_WIDTH-1:0] elem_t;

  // Controller state encodings.
  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t CLEAR = 3'd1;
  localparam state_t RUN   = 3'd2;
  localparam state_t CHECK = 3'd3;
  localparam state_t DONE  = 3'd4;

  // Canonical state element values. All-ones is the two's complement -1.
  localparam elem_t STATE_POS  = elem_t'(1);
  localparam elem_t STATE_NEG  = '1;
  localparam elem_t STATE_ZERO = '0;

endpackage

// File: rtl/hopfield_iter_ctrl_done_collector.sv
// ---------------------------------------------------------------------------
// done_collector
//
// Gathers the per-neuron results of one update pass.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   clear         - start of a new pass: drops the sticky mask and the
//                   wait counter
//   active        - the pass is running; results are only collected while
//                   this is high
//   done_in[N]    - neuron done flags
//   snext_in      - concatenated neuron Snext outputs (element i at
//                   [SIZE*i +: SIZE])
//   snext_q       - captured next-state vector
//   all_done      - every neuron has reported at least once this pass,
//                   including flags arriving in the current cycle
//   timeout       - the wait budget has run out without all_done
// ---------------------------------------------------------------------------
module done_collector
  import hopfield_pkg::*;
#(
  parameter int N       = 4,
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            active,
  input  logic [N-1:0]    done_in,
  input  logic [SIZE*N-1:0] snext_in,
  output logic [SIZE*N-1:0] snext_q,
  output logic            all_done,
  output logic            timeout
);

  // Wide enough to hold TIMEOUT-1 even when TIMEOUT is 1.
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [N-1:0]  done_mask;
  logic [WW-1:0] wait_cnt;
  logic [N-1:0]  mask_next;

  // The current cycle's flags count immediately, so the pass can finish in
  // the same cycle the last neuron reports.
  assign mask_next = done_mask | done_in;
  assign all_done  = active && (&mask_next);
  assign timeout   = active && !(&mask_next) && (wait_cnt == WW'(TIMEOUT - 1));

  // Sticky done mask and pass wait counter. Both restart on clear and only
  // advance while the pass is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_mask <= '0;
      wait_cnt  <= '0;
    end else if (clear) begin
      done_mask <= '0;
      wait_cnt  <= '0;
    end else if (active) begin
      done_mask <= mask_next;
      wait_cnt  <= wait_cnt + WW'(1);
    end
  end

  // Per-element capture. A neuron that pulses done more than once in a pass
  // simply overwrites its slot, so the last reported value is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      snext_q <= '0;
    end else if (active) begin
      for (int i = 0; i < N; i++) begin
        if (done_in[i]) begin
          snext_q[SIZE*i +: SIZE] <= snext_in[SIZE*i +: SIZE];
        end
      end
    end
  end

endmodule

// File: rtl/hopfield_iter_ctrl.sv
// ---------------------------------------------------------------------------
// hopfield_iter_ctrl
//
// Iteration controller around an array of N neurons. It loads an initial
// state, runs update passes (clear neurons, enable them, collect Snext/done),
// stops on convergence, on the iteration limit, or on a done timeout, and
// hands the final state to the host over a valid/ready handshake.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   start           - request a run, accepted only in IDLE
//   init_state      - initial state vector, sampled when start is accepted
//   scurr           - registered current state fed to every neuron
//   neuron_en       - neuron enable, high only during RUN
//   neuron_rst_n    - active-low neuron clear, low only during CLEAR
//   snext_in        - concatenated neuron Snext outputs
//   done_in         - neuron done flags
//   out_state       - final state (valid with out_valid)
//   out_valid       - result available, held until out_ready
//   out_ready       - host accepts the result
//   converged       - last pass left the state unchanged
//   error           - run aborted on a done timeout
//   iter_count      - passes completed
//   busy            - controller is not IDLE
// ---------------------------------------------------------------------------
module hopfield_iter_ctrl
  import hopfield_pkg::*;
#(
  parameter int N        = 4,
  parameter int SIZE     = 32,
  parameter int MAX_ITER = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [SIZE*N-1:0]             init_state,
  output logic [SIZE*N-1:0]             scurr,
  output logic                          neuron_en,
  output logic                          neuron_rst_n,
  input  logic [SIZE*N-1:0]             snext_in,
  input  logic [N-1:0]                  done_in,
  output logic [SIZE*N-1:0]             out_state,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          converged,
  output logic                          error,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
  output logic                          busy
);

  localparam int IW = $clog2(MAX_ITER + 1);

  state_t              state;
  logic [SIZE*N-1:0]   scurr_reg;
  logic [SIZE*N-1:0]   snext_reg;
  logic [IW-1:0]       iter_reg;
  logic                converged_reg;
  logic                error_reg;
  logic                all_done;
  logic                timeout;
  logic                in_clear;
  logic                in_run;
  logic                last_pass;
  logic                unchanged;

  assign in_clear = (state == CLEAR);
  assign in_run   = (state == RUN);

  done_collector #(
    .N       (N),
    .SIZE    (SIZE),
    .TIMEOUT (TIMEOUT)
  ) u_collector (
    .clk      (clk),
    .rst      (rst),
    .clear    (in_clear),
    .active   (in_run),
    .done_in  (done_in),
    .snext_in (snext_in),
    .snext_q  (snext_reg),
    .all_done (all_done),
    .timeout  (timeout)
  );

  // Full-width bitwise compare, so 0, +1 and -1 are all distinct values.
  assign unchanged = (snext_reg == scurr_reg);
  // The pass finishing in CHECK is the last one allowed.
  assign last_pass = ((32'(iter_reg) + 32'd1) == 32'(MAX_ITER));

  // Main controller: sequences passes and keeps the result registers.
  // Result flags are cleared on an accepted start so a new run never shows
  // stale status from the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      scurr_reg     <= '0;
      iter_reg      <= '0;
      converged_reg <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            scurr_reg     <= init_state;
            iter_reg      <= '0;
            converged_reg <= 1'b0;
            error_reg     <= 1'b0;
            state         <= CLEAR;
          end
        end
        CLEAR: begin
          state <= RUN;
        end
        RUN: begin
          if (all_done) begin
            state <= CHECK;
          end else if (timeout) begin
            error_reg <= 1'b1;
            state     <= DONE;
          end
        end
        CHECK: begin
          iter_reg <= iter_reg + IW'(1);
          if (unchanged) begin
            converged_reg <= 1'b1;
            state         <= DONE;
          end else if (last_pass) begin
            state <= DONE;
          end else begin
            scurr_reg <= snext_reg;
            state     <= CLEAR;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from the state register, so they are glitch-free
  // and hold steady for as long as the state does.
  assign scurr        = scurr_reg;
  assign neuron_en    = in_run;
  assign neuron_rst_n = !in_clear;
  assign out_valid    = (state == DONE);
  assign busy         = (state != IDLE);
  assign converged    = converged_reg;
  assign error        = error_reg;
  assign iter_count   = iter_reg;

  // On a timeout the partially collected Snext vector is meaningless, so the
  // last complete state is reported instead.
  always_comb begin
    out_state = '0;
    if (state == DONE) begin
      out_state = error_reg ? scurr_reg : snext_reg;
    end
  end

endmodule

// File: doc/hopfield_iter_ctrl.md
# hopfield_iter_ctrl

Iteration controller for the Hopfield network datapath. It sits around the array of N `neuron` instances: upstream it drives their shared state vector, enable and per-iteration clear; downstream it consumes their `Snext`/`done` outputs. It assembles the next state, detects convergence (state unchanged) or the iteration limit, and then either feeds the new state back for another pass or presents the final state to the host through a valid/ready handshake.

## Interface
- Parameters:
  - `N` (4): number of neurons / state elements.
  - `SIZE` (32): bit width of one state element.
  - `MAX_ITER` (16): maximum number of update passes; must be ≥1.
  - `TIMEOUT` (64): maximum cycles to wait in RUN for all neuron `done` flags.
- Ports:
  - `clk` in 1: single clock; all logic on its rising edge.
  - `rst` in 1: reset, synchronous, active-high.
  - `start` in 1: request a run; accepted only in IDLE.
  - `init_state` in SIZE*N: initial state vector, sampled when `start` is accepted. Element i is at bits [SIZE*i +: SIZE].
  - `scurr` out SIZE*N: current state, wired to every neuron's `Scurr`.
  - `neuron_en` out 1: neuron enable.
  - `neuron_rst_n` out 1: active-low clear to the neurons.
  - `snext_in` in SIZE*N: concatenated neuron `Snext` outputs.
  - `done_in` in N: neuron `done` flags.
  - `out_state` out SIZE*N: final state.
  - `out_valid` out 1: `out_state`, `converged`, `iter_count` and `error` are valid.
  - `out_ready` in 1: host accepts the result.
  - `converged` out 1: the last pass produced an unchanged state.
  - `error` out 1: the run aborted on a timeout.
  - `iter_count` out $clog2(MAX_ITER+1): number of passes completed.
  - `busy` out 1: high whenever the state is not IDLE.

## Operation
- States and transitions:
  - IDLE: on `start`, go to CLEAR.
  - CLEAR: always go to RUN.
  - RUN: when all `done` flags have been seen, go to CHECK; on timeout, go to DONE.
  - CHECK: go to DONE or back to CLEAR.
  - DONE: on `out_ready`, go to IDLE.
- IDLE, `start`=1:
  - `scurr_reg` <= `init_state`.
  - `iter_count` <= 0; `converged` <= 0; `error` <= 0.
- CLEAR (1 cycle):
  - `neuron_rst_n`=0 and `neuron_en`=0. This clears the neuron counters and sums.
  - `done_mask` <= 0; `wait_cnt` <= 0.
- RUN:
  - `neuron_en`=1.
  - Each cycle: `done_mask` <= `done_mask` | `done_in`; `snext_reg[i]` <= `snext_in[i]` for every i with `done_in[i]`=1.
  - When (`done_mask` | `done_in`) is all ones, go to CHECK with `neuron_en` dropping to 0.
  - `wait_cnt` increments each cycle. If `wait_cnt` == TIMEOUT-1 without all flags seen, set `error`=1 and go to DONE.
- CHECK (1 cycle):
  - `neuron_en`=0; `iter_count` <= `iter_count`+1.
  - If `snext_reg` == `scurr_reg`: set `converged`=1 and go to DONE.
  - Else, if `iter_count`+1 == MAX_ITER: go to DONE with `converged`=0.
  - Else: `scurr_reg` <= `snext_reg` and go to CLEAR.
- DONE:
  - `out_valid`=1 and `out_state` = `snext_reg`. On error, `out_state` = `scurr_reg`.
  - All outputs are held stable until `out_ready`=1. That cycle is the transfer; the next state is IDLE.
- State elements are compared bitwise across the full SIZE width; values 0, +1 and all-ones (−1) are all treated as distinct.
- `start` is ignored outside IDLE. `start` in the same cycle as the transfer is also ignored, because the block is still in DONE.
- Duplicate `done_in` pulses from one neuron within a pass overwrite `snext_reg[i]`; the last value wins.

## Timing
- Reset values: `neuron_en`=0, `neuron_rst_n`=1, `out_valid`=0, `converged`=0, `error`=0, `busy`=0, `iter_count`=0, `scurr`=0, `out_state`=0. The state register resets to IDLE.
- Reset in any state: the block returns to IDLE on the next edge and drops `neuron_en`. An in-flight result is discarded.
- `busy` rises the cycle after `start` is accepted.
- `scurr` is registered. It changes only on the `start` cycle or in CHECK, so it is stable throughout CLEAR and RUN.
- Latency per pass = 1 (CLEAR) + R (RUN cycles until the last `done`) + 1 (CHECK). With the standard neuron, R ≈ N+2.
- `out_valid` rises the cycle after CHECK, or the cycle after the timeout is detected.

## Structure
- Shared package `hopfield_pkg`:
  - state enum {IDLE, CLEAR, RUN, CHECK, DONE};
  - `STATE_POS`=1, `STATE_NEG`='1, `STATE_ZERO`=0;
  - typedef `elem_t` [SIZE-1:0].
- One sub-module, `done_collector`: holds the sticky mask, per-element capture, `all_done` and the timeout counter.

## Test plan
- N=4, SIZE=32. Neuron model returns `snext`=`scurr` after 6 cycles. Start with {1,−1,1,−1} → `out_valid`, `converged`=1, `iter_count`=1, `out_state`={1,−1,1,−1}.
- Model flips element 0 on pass 1 only. Start with {1,1,1,1} → `iter_count`=2, `converged`=1, `out_state`={−1,1,1,1}.
- MAX_ITER=3, model toggles every element on every pass → `iter_count`=3, `converged`=0.
- `done_in` for neurons 0–3 arrives on 4 different cycles → one CHECK only; each `snext` is captured from its own pulse.
- Neuron 2 never asserts `done` → `error`=1 after TIMEOUT cycles in RUN; `out_state`=`init_state`. Holding `out_ready`=0 for 5 cycles keeps the outputs stable.
- Assert `rst` mid-RUN → next cycle `busy`=0, `neuron_en`=0, `out_valid`=0. A following `start` runs normally.
